// File: rtl/rob_param.sv
// Circular reorder buffer: in-order allocation from dispatch, out-of-order
// writeback on an ALU/branch port and a load port, in-order single retire,
// with branch/jump redirect that flushes the whole buffer.
module rob_param #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  // dispatch
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [1:0]       disp_kind,
  input  logic [4:0]       disp_rd,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic             disp_len2,
  input  logic             disp_pred,
  output logic [TAG_W-1:0] disp_tag,
  // ALU / branch-unit writeback
  input  logic             wb0_valid,
  input  logic [TAG_W-1:0] wb0_tag,
  input  logic [XLEN-1:0]  wb0_value,
  input  logic             wb0_taken,
  // load writeback
  input  logic             wb1_valid,
  input  logic [TAG_W-1:0] wb1_tag,
  input  logic [XLEN-1:0]  wb1_value,
  // retire
  output logic             cm_valid,
  output logic [4:0]       cm_rd,
  output logic [XLEN-1:0]  cm_value,
  output logic [TAG_W-1:0] cm_tag,
  output logic             cm_store,
  // redirect
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc,
  // occupancy
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;
  localparam logic [1:0] KIND_JUMP   = 2'd3;

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  // Per-entry state; valid/ready are packed so they can be cleared in one shot.
  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_ready;
  logic [1:0]       e_kind   [DEPTH];
  logic [4:0]       e_rd     [DEPTH];
  logic [XLEN-1:0]  e_alt    [DEPTH];
  logic [XLEN-1:0]  e_value  [DEPTH];
  logic [XLEN-1:0]  e_target [DEPTH];
  logic             e_taken  [DEPTH];
  logic             e_pred   [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic             retire;
  logic             head_redirect;
  logic             flush_now;
  logic             disp_fire;
  logic             wb0_hit;
  logic             wb1_hit;
  logic [XLEN-1:0]  disp_alt;
  logic [TAG_W:0]   count_nxt;

  // Retire/redirect decode of the head entry, dispatch handshake, writeback qualification
  always_comb begin
    retire        = e_valid[head] && e_ready[head];
    head_redirect = (e_kind[head] == KIND_JUMP) ||
                    ((e_kind[head] == KIND_BRANCH) && (e_taken[head] != e_pred[head]));
    flush_now     = retire && head_redirect;
    disp_ready    = !full && !flush_now;
    disp_fire     = disp_valid && disp_ready;
    disp_tag      = tail;
    disp_alt      = disp_pc + (disp_len2 ? XLEN'(2) : XLEN'(4));
    wb0_hit       = wb0_valid && e_valid[wb0_tag] && !e_ready[wb0_tag] && !flush_now;
    // wb0 has priority when both ports name the same entry
    wb1_hit       = wb1_valid && e_valid[wb1_tag] && !e_ready[wb1_tag] && !flush_now &&
                    !(wb0_valid && (wb0_tag == wb1_tag));
  end

  // Next occupancy: flush empties the buffer, otherwise +dispatch -retire
  always_comb begin
    count_nxt = count;
    if (flush_now)
      count_nxt = '0;
    else if (disp_fire && !retire)
      count_nxt = count + CNT_ONE;
    else if (retire && !disp_fire)
      count_nxt = count - CNT_ONE;
  end

  // Entry valid/ready bookkeeping; reset and flush both invalidate every slot
  always_ff @(posedge clk) begin
    if (!rst || flush_now) begin
      e_valid <= '0;
      e_ready <= '0;
    end else begin
      if (retire) begin
        e_valid[head] <= 1'b0;
        e_ready[head] <= 1'b0;
      end
      if (wb0_hit)
        e_ready[wb0_tag] <= 1'b1;
      if (wb1_hit)
        e_ready[wb1_tag] <= 1'b1;
      if (disp_fire) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= (disp_kind == KIND_STORE);
      end
    end
  end

  // Entry payload; only meaningful while the slot is valid, so no reset needed
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      e_kind[tail]   <= disp_kind;
      e_rd[tail]     <= disp_rd;
      e_alt[tail]    <= disp_alt;
      e_pred[tail]   <= disp_pred;
      e_taken[tail]  <= 1'b0;
      e_target[tail] <= '0;
      e_value[tail]  <= (disp_kind == KIND_JUMP) ? disp_alt : '0;
    end
    if (wb0_hit) begin
      case (e_kind[wb0_tag])
        KIND_BRANCH: begin
          e_taken[wb0_tag]  <= wb0_taken;
          e_target[wb0_tag] <= wb0_value;
        end
        KIND_JUMP:   e_target[wb0_tag] <= wb0_value;
        default:     e_value[wb0_tag]  <= wb0_value;
      endcase
    end
    if (wb1_hit)
      e_value[wb1_tag] <= wb1_value;
  end

  // Pointers, occupancy flags and registered retire/redirect outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      cm_valid <= 1'b0;
      cm_store <= 1'b0;
      cm_rd    <= '0;
      cm_value <= '0;
      cm_tag   <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      cm_valid <= retire;
      cm_store <= retire && (e_kind[head] == KIND_STORE);
      flush    <= flush_now;
      if (retire) begin
        cm_rd    <= ((e_kind[head] == KIND_REG) || (e_kind[head] == KIND_JUMP)) ? e_rd[head] : '0;
        cm_value <= e_value[head];
        cm_tag   <= head;
      end
      if (flush_now)
        flush_pc <= ((e_kind[head] == KIND_JUMP) || e_taken[head]) ? e_target[head] : e_alt[head];
      if (flush_now) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (retire)
          head <= head + TAG_ONE;
        if (disp_fire)
          tail <= tail + TAG_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: fill/stall, out-of-order writeback,
// mispredict and jump redirects, wrap-around streaming, mid-run reset.
module tb_rob_param;

  logic        clk;
  logic        rst;
  logic        disp_valid;
  logic        disp_ready;
  logic [1:0]  disp_kind;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc;
  logic        disp_len2;
  logic        disp_pred;
  logic [2:0]  disp_tag;
  logic        wb0_valid;
  logic [2:0]  wb0_tag;
  logic [31:0] wb0_value;
  logic        wb0_taken;
  logic        wb1_valid;
  logic [2:0]  wb1_tag;
  logic [31:0] wb1_value;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [31:0] cm_value;
  logic [2:0]  cm_tag;
  logic        cm_store;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  rob_param #(.DEPTH(8), .TAG_W(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_kind(disp_kind),
    .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_len2(disp_len2),
    .disp_pred(disp_pred), .disp_tag(disp_tag),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value), .wb0_taken(wb0_taken),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_tag(cm_tag),
    .cm_store(cm_store), .flush(flush), .flush_pc(flush_pc),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [1:0] k, input logic [4:0] rd,
                          input logic [31:0] pc, input logic l2, input logic pr);
    disp_valid = v; disp_kind = k; disp_rd = rd; disp_pc = pc; disp_len2 = l2; disp_pred = pr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (cm_valid !== 1'b0 || flush !== 1'b0 || cm_store !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0b%0b%0b exp=000", cm_valid, flush, cm_store); end
    total++; if (disp_ready !== 1'b1 || disp_tag !== 3'd0) begin bad++; $display("FAIL reset_disp got=%0b/%0d exp=1/0", disp_ready, disp_tag); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_disp(1'b1, 2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      #1;
      total++; if (disp_tag !== 3'(i) || disp_ready !== 1'b1) begin bad++; $display("FAIL fill_tag got=%0d/%0b exp=%0d/1", disp_tag, disp_ready, i); end
      tick();
    end
    // ninth request must stall
    set_disp(1'b1, 2'd0, 5'd9, 32'h2000, 1'b0, 1'b0);
    #1;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", full); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", count); end
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", disp_ready); end
    tick();
    total++; if (count !== 4'd8 || cm_valid !== 1'b0) begin bad++; $display("FAIL fill_stall got=%0d/%0b exp=8/0", count, cm_valid); end
    disp_valid = 1'b0;
  endtask

  task automatic test_ooo_wb();
    wb0_valid = 1'b1; wb0_tag = 3'd2; wb0_value = 32'h22; wb0_taken = 1'b0;
    tick();
    total++; if (cm_valid !== 1'b0) begin bad++; $display("FAIL ooo_early_retire got=%0b exp=0", cm_valid); end
    wb0_tag = 3'd0; wb0_value = 32'h00;
    tick();
    wb0_tag = 3'd1; wb0_value = 32'h11;
    tick();
    wb0_valid = 1'b0;
    total++; if (cm_valid !== 1'b1 || cm_value !== 32'h00 || cm_tag !== 3'd0 || cm_rd !== 5'd1) begin bad++; $display("FAIL ooo_ret0 got=%0b/%h/%0d/%0d exp=1/0/0/1", cm_valid, cm_value, cm_tag, cm_rd); end
    tick();
    total++; if (cm_valid !== 1'b1 || cm_value !== 32'h11 || cm_tag !== 3'd1 || cm_rd !== 5'd2) begin bad++; $display("FAIL ooo_ret1 got=%0b/%h/%0d/%0d exp=1/11/1/2", cm_valid, cm_value, cm_tag, cm_rd); end
    tick();
    total++; if (cm_valid !== 1'b1 || cm_value !== 32'h22 || cm_tag !== 3'd2 || cm_rd !== 5'd3) begin bad++; $display("FAIL ooo_ret2 got=%0b/%h/%0d/%0d exp=1/22/2/3", cm_valid, cm_value, cm_tag, cm_rd); end
    tick();
    total++; if (cm_valid !== 1'b0 || count !== 4'd5) begin bad++; $display("FAIL ooo_after got=%0b/%0d exp=0/5", cm_valid, count); end
  endtask

  task automatic test_wb_collide_drain();
    // both ports name tag 3 in one cycle: wb0 value must be kept
    wb0_valid = 1'b1; wb0_tag = 3'd3; wb0_value = 32'hA3; wb0_taken = 1'b0;
    wb1_valid = 1'b1; wb1_tag = 3'd3; wb1_value = 32'hB3;
    tick();
    wb0_valid = 1'b0;
    for (int j = 4; j < 8; j++) begin
      wb1_tag = 3'(j); wb1_value = 32'(j * 17);
      tick();
      total++; if (cm_valid !== 1'b1 || cm_tag !== 3'(j - 1) || cm_value !== ((j == 4) ? 32'hA3 : 32'((j - 1) * 17))) begin bad++; $display("FAIL drain_ret got=%0b/%0d/%h exp tag=%0d", cm_valid, cm_tag, cm_value, j - 1); end
    end
    wb1_valid = 1'b0;
    tick();
    total++; if (cm_tag !== 3'd7 || cm_value !== 32'h77) begin bad++; $display("FAIL drain_last got=%0d/%h exp=7/77", cm_tag, cm_value); end
    total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0d/%0b exp=0/1", count, empty); end
  endtask

  task automatic test_mispredict();
    set_disp(1'b1, 2'd2, 5'd0, 32'h100, 1'b0, 1'b1);
    #1;
    total++; if (disp_tag !== 3'd0) begin bad++; $display("FAIL mp_tag got=%0d exp=0", disp_tag); end
    tick();
    set_disp(1'b1, 2'd0, 5'd5, 32'h104, 1'b0, 1'b0);
    tick();
    set_disp(1'b1, 2'd0, 5'd6, 32'h108, 1'b0, 1'b0);
    tick();
    disp_valid = 1'b0;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL mp_count3 got=%0d exp=3", count); end
    wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_value = 32'h51; wb0_taken = 1'b0;
    wb1_valid = 1'b1; wb1_tag = 3'd2; wb1_value = 32'h61;
    tick();
    wb1_valid = 1'b0;
    wb0_tag = 3'd0; wb0_value = 32'h300; wb0_taken = 1'b0;
    tick();
    wb0_valid = 1'b0;
    total++; if (cm_valid !== 1'b0) begin bad++; $display("FAIL mp_no_early got=%0b exp=0", cm_valid); end
    // branch at head now resolving as mispredicted: dispatch is blocked
    set_disp(1'b1, 2'd0, 5'd7, 32'h10C, 1'b0, 1'b0);
    #1;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL mp_block got=%0b exp=0", disp_ready); end
    tick();
    disp_valid = 1'b0;
    total++; if (flush !== 1'b1 || flush_pc !== 32'h104) begin bad++; $display("FAIL mp_flush got=%0b/%h exp=1/104", flush, flush_pc); end
    total++; if (cm_valid !== 1'b1 || cm_tag !== 3'd0 || cm_rd !== 5'd0) begin bad++; $display("FAIL mp_retire got=%0b/%0d/%0d exp=1/0/0", cm_valid, cm_tag, cm_rd); end
    total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL mp_count got=%0d/%0b exp=0/1", count, empty); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (cm_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL mp_younger got=%0b/%0b exp=0/0", cm_valid, flush); end
    end
  endtask

  task automatic test_correct_branch();
    set_disp(1'b1, 2'd2, 5'd0, 32'h180, 1'b0, 1'b1);
    #1;
    total++; if (disp_tag !== 3'd0) begin bad++; $display("FAIL cb_tag got=%0d exp=0", disp_tag); end
    tick();
    disp_valid = 1'b0;
    wb0_valid = 1'b1; wb0_tag = 3'd0; wb0_value = 32'h500; wb0_taken = 1'b1;
    tick();
    wb0_valid = 1'b0;
    tick();
    total++; if (cm_valid !== 1'b1 || flush !== 1'b0 || flush_pc !== 32'h104 || count !== 4'd0) begin bad++; $display("FAIL cb_noflush got=%0b/%0b/%h/%0d exp=1/0/104/0", cm_valid, flush, flush_pc, count); end
  endtask

  task automatic test_jal();
    set_disp(1'b1, 2'd3, 5'd1, 32'h200, 1'b1, 1'b0);
    #1;
    total++; if (disp_tag !== 3'd1) begin bad++; $display("FAIL jal_tag got=%0d exp=1", disp_tag); end
    tick();
    disp_valid = 1'b0;
    wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_value = 32'h400; wb0_taken = 1'b0;
    tick();
    wb0_valid = 1'b0;
    tick();
    total++; if (cm_valid !== 1'b1 || cm_rd !== 5'd1 || cm_value !== 32'h202 || cm_tag !== 3'd1) begin bad++; $display("FAIL jal_cm got=%0b/%0d/%h/%0d exp=1/1/202/1", cm_valid, cm_rd, cm_value, cm_tag); end
    total++; if (flush !== 1'b1 || flush_pc !== 32'h400 || count !== 4'd0) begin bad++; $display("FAIL jal_flush got=%0b/%h/%0d exp=1/400/0", flush, flush_pc, count); end
  endtask

  task automatic test_wrap();
    int exp_cnt;
    for (int i = 0; i < 22; i++) begin
      disp_valid = (i < 20); disp_kind = 2'd0; disp_rd = 5'(i + 1);
      disp_pc = 32'h3000 + 32'(4 * i); disp_len2 = 1'b0; disp_pred = 1'b0;
      wb0_valid = (i >= 1 && i <= 20);
      wb0_tag = 3'((i + 7) % 8); wb0_value = 32'h1000 + 32'(i) - 32'd1; wb0_taken = 1'b0;
      #1;
      if (i < 20) begin
        total++; if (disp_ready !== 1'b1 || disp_tag !== 3'(i % 8)) begin bad++; $display("FAIL wrap_disp i=%0d got=%0b/%0d exp=1/%0d", i, disp_ready, disp_tag, i % 8); end
      end
      tick();
      if (i >= 2) begin
        total++; if (cm_valid !== 1'b1 || cm_tag !== 3'((i - 2) % 8) || cm_value !== 32'h1000 + 32'(i - 2) || cm_rd !== 5'(i - 1)) begin bad++; $display("FAIL wrap_ret i=%0d got=%0b/%0d/%h/%0d", i, cm_valid, cm_tag, cm_value, cm_rd); end
      end
      exp_cnt = (i < 20) ? ((i < 2) ? i + 1 : 2) : 21 - i;
      total++; if (count !== 4'(exp_cnt)) begin bad++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, count, exp_cnt); end
    end
    disp_valid = 1'b0; wb0_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      set_disp(1'b1, 2'd0, 5'(10 + i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
      #1;
      total++; if (disp_tag !== 3'((4 + i) % 8)) begin bad++; $display("FAIL rm_tag got=%0d exp=%0d", disp_tag, (4 + i) % 8); end
      tick();
    end
    disp_valid = 1'b0;
    total++; if (count !== 4'd5) begin bad++; $display("FAIL rm_count5 got=%0d exp=5", count); end
    wb0_valid = 1'b1; wb0_tag = 3'd4; wb0_value = 32'h99; wb0_taken = 1'b0;
    tick();
    wb0_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rm_state got=%0d/%0b/%0b exp=0/1/0", count, empty, full); end
    total++; if (cm_valid !== 1'b0 || cm_tag !== 3'd0 || cm_value !== 32'd0) begin bad++; $display("FAIL rm_cm got=%0b/%0d/%h exp=0/0/0", cm_valid, cm_tag, cm_value); end
    tick();
    total++; if (cm_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL rm_discard got=%0b/%0d exp=0/0", cm_valid, count); end
    set_disp(1'b1, 2'd1, 5'd9, 32'h300, 1'b0, 1'b0);
    #1;
    total++; if (disp_tag !== 3'd0) begin bad++; $display("FAIL st_tag got=%0d exp=0", disp_tag); end
    tick();
    disp_valid = 1'b0;
    tick();
    total++; if (cm_valid !== 1'b1 || cm_store !== 1'b1 || cm_rd !== 5'd0 || cm_tag !== 3'd0) begin bad++; $display("FAIL st_retire got=%0b/%0b/%0d/%0d exp=1/1/0/0", cm_valid, cm_store, cm_rd, cm_tag); end
    tick();
    total++; if (cm_valid !== 1'b0 || cm_store !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL st_pulse got=%0b/%0b/%0b exp=0/0/1", cm_valid, cm_store, empty); end
  endtask

  initial begin
    rst = 1'b0;
    set_disp(1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    wb0_valid = 1'b0; wb0_tag = '0; wb0_value = '0; wb0_taken = 1'b0;
    wb1_valid = 1'b0; wb1_tag = '0; wb1_value = '0;
    test_reset();
    test_fill();
    test_ooo_wb();
    test_wb_collide_drain();
    test_mispredict();
    test_correct_branch();
    test_jal();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
